piso_serializer: RTL

- Parallel-in/serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock, with frame markers.
- It is the driving end of a single-bit serial link. The receiving end samples ser_out into capture flip-flops on posedge clk.
- Bit pacing is controlled externally via bit_en, so the same block serves full-rate and divided-rate links.

---
 rtl/piso_serializer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load and bit_en pacing.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             bit_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PEN_IDX  = CW'(WIDTH - 2);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef PISO_SERIALIZER_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_SHIFT  = 2'd1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par_q, par_d;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w[WIDTH-1];
    else                return w[0];
  endfunction

  // The bit on the wire is always at the "first" end, so shifting moves the next bit there.
  function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return {w[WIDTH-2:0], 1'b0};
    else                return {1'b0, w[WIDTH-1:1]};
  endfunction

  assign load_ready = (state_q == ST_IDLE);
  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign ser_last   = ser_last_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) state_d = ST_SHIFT;
        else            state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (bit_en && (cnt_q == LAST_IDX)) begin
`ifdef PISO_SERIALIZER_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_SHIFT;
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        if (bit_en) state_d = ST_IDLE;
        else        state_d = ST_PARITY;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    ser_last_d  = ser_last_q;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          shift_d     = load_data;
          cnt_d       = '0;
          ser_out_d   = first_bit(load_data);
          ser_valid_d = 1'b1;
          ser_last_d  = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
          par_d       = even_parity(load_data);
`endif
        end else begin
          cnt_d       = '0;
          ser_out_d   = 1'b0;
          ser_valid_d = 1'b0;
          ser_last_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (bit_en && (cnt_q != LAST_IDX)) begin
          shift_d     = shift_next(shift_q);
          cnt_d       = cnt_q + CW'(1);
          ser_out_d   = first_bit(shift_next(shift_q));
          ser_valid_d = 1'b1;
          ser_last_d  = (cnt_q == PEN_IDX) && !PAR_EN;
        end else if (bit_en) begin
`ifdef PISO_SERIALIZER_PARITY_EN
          ser_out_d   = par_q;
          ser_valid_d = 1'b1;
          ser_last_d  = 1'b1;
`else
          cnt_d       = '0;
          ser_out_d   = 1'b0;
          ser_valid_d = 1'b0;
          ser_last_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q;
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        if (bit_en) begin
          cnt_d       = '0;
          ser_out_d   = 1'b0;
          ser_valid_d = 1'b0;
          ser_last_d  = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
`endif
      default: begin
        cnt_d       = '0;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
      end
    endcase
  end

endmodule
